// File: rtl/acia_fifo.sv
// acia_fifo: UART with TX/RX FIFOs, 5..8 data bits, 1/2 stop bits, sticky error
// flags and an interrupt output, behind a two-register CPU interface
// (rs_i=0 status/control, rs_i=1 data).
// Optional parity bit: define ACIA_PARITY_EN (polarity chosen by PARITY_ODD).
module acia_fifo #(
  parameter int CLK_HZ     = 25_125_000,
  parameter int BPS_RATE   = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       rd_i,
  input  logic       wr_i,
  input  logic       rs_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  input  logic       rx_i,
  output logic       tx_o,
  output logic       rx_avail_o,
  output logic       tx_space_o,
  output logic       irq_o
);
  localparam int DIV  = (CLK_HZ + BPS_RATE / 2) / BPS_RATE;
  localparam int TW   = $clog2(DIV + 1);
  localparam int TAW  = $clog2(TX_DEPTH);
  localparam int RAW  = $clog2(RX_DEPTH);
  localparam int TPW  = TAW + 1;
  localparam int RPW  = RAW + 1;

  if (DIV < 8) begin : g_div_chk
    $error("acia_fifo: CLK_HZ/BPS_RATE must be >= 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_db_chk
    $error("acia_fifo: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_sb_chk
    $error("acia_fifo: STOP_BITS must be 1 or 2");
  end
  if (TX_DEPTH < 2 || (TX_DEPTH & (TX_DEPTH - 1)) != 0) begin : g_txd_chk
    $error("acia_fifo: TX_DEPTH must be a power of 2 >= 2");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0) begin : g_rxd_chk
    $error("acia_fifo: RX_DEPTH must be a power of 2 >= 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
    $error("acia_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK} rx_state_e;

  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [TAW:0] tx_wr, tx_rd, tx_wr_n, tx_rd_n;
  logic [RAW:0] rx_wr, rx_rd, rx_wr_n, rx_rd_n;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic data_wr, ctl_wr, tx_flush, rx_flush, flag_clr;
  logic tx_pop, tx_push, tx_bit_end, tx_ready, txovf_set;
  logic rx_pop, rx_push, rx_push_req, rx_bit_end, ovr_set, fe_set;
  logic ovr, fe, txovf, ovr_n, fe_n, txovf_n, pe_bit, pe_n, txi;
  logic [DATA_BITS-1:0] tx_head, rx_head, tx_shift, rx_shift;
  logic [7:0] status;
  tx_state_e tx_st;
  rx_state_e rx_st;
  logic [TW-1:0] tx_tmr, rx_tmr;
  logic [2:0] tx_idx, rx_idx;
  logic rx_meta, rx_sync, rx_prev;
`ifdef ACIA_PARITY_EN
  logic tx_par, rx_pbad, pe;
`endif

  assign data_wr  = wr_i & rs_i;
  assign ctl_wr   = wr_i & ~rs_i;
  assign tx_flush = ctl_wr & din_i[1];
  assign rx_flush = ctl_wr & din_i[0];
  assign flag_clr = (rd_i & ~rs_i) | (ctl_wr & din_i[2]);

  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[TAW] != tx_rd[TAW]) && (tx_wr[TAW-1:0] == tx_rd[TAW-1:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[RAW] != rx_rd[RAW]) && (rx_wr[RAW-1:0] == rx_rd[RAW-1:0]);
  assign tx_head  = tx_mem[tx_rd[TAW-1:0]];
  assign rx_head  = rx_mem[rx_rd[RAW-1:0]];

  // The shifter takes the next byte from idle or at the end of the last stop bit,
  // so queued frames go out back to back.
  assign tx_bit_end = (tx_tmr == TW'(DIV - 1));
  assign tx_ready   = (tx_st == T_IDLE) |
                      ((tx_st == T_STOP) & tx_bit_end & (tx_idx == 3'(STOP_BITS - 1)));
  assign tx_pop     = tx_ready & ~tx_empty & ~tx_flush;
  assign tx_push    = data_wr & (~tx_full | tx_pop);
  assign txovf_set  = data_wr & tx_full & ~tx_pop;

  assign rx_bit_end  = (rx_tmr == TW'(DIV - 1));
  assign rx_push_req = (rx_st == R_STOP) & rx_bit_end & rx_sync;
  assign fe_set      = (rx_st == R_STOP) & rx_bit_end & ~rx_sync;
  assign rx_pop      = rd_i & rs_i & ~rx_empty;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign ovr_set     = rx_push_req & rx_full & ~rx_pop;

  assign tx_wr_n = tx_wr + TPW'(tx_push);
  assign tx_rd_n = tx_flush ? tx_wr : tx_rd + TPW'(tx_pop);
  assign rx_wr_n = rx_wr + RPW'(rx_push);
  assign rx_rd_n = rx_flush ? rx_wr : rx_rd + RPW'(rx_pop);

  // Sticky flags: a set in the same cycle as a clear wins.
  assign ovr_n   = ovr_set   | (ovr   & ~flag_clr);
  assign fe_n    = fe_set    | (fe    & ~flag_clr);
  assign txovf_n = txovf_set | (txovf & ~flag_clr);
`ifdef ACIA_PARITY_EN
  assign pe_n    = (rx_push_req & rx_pbad) | (pe & ~flag_clr);
  assign pe_bit  = pe;
`else
  assign pe_n    = 1'b0;
  assign pe_bit  = 1'b0;
`endif

  assign txi    = tx_empty & (tx_st == T_IDLE);
  assign status = {1'b0, txovf, pe_bit, fe, txi, ovr, ~tx_full, ~rx_empty};

  // FIFO pointers, sticky flags and registered CPU-side outputs
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr      <= '0;
      tx_rd      <= '0;
      rx_wr      <= '0;
      rx_rd      <= '0;
      ovr        <= 1'b0;
      fe         <= 1'b0;
      txovf      <= 1'b0;
      dout_o     <= 8'h00;
      rx_avail_o <= 1'b0;
      tx_space_o <= 1'b1;
      irq_o      <= 1'b0;
    end else begin
      tx_wr      <= tx_wr_n;
      tx_rd      <= tx_rd_n;
      rx_wr      <= rx_wr_n;
      rx_rd      <= rx_rd_n;
      ovr        <= ovr_n;
      fe         <= fe_n;
      txovf      <= txovf_n;
      dout_o     <= rs_i ? 8'(rx_head) : status;
      rx_avail_o <= (rx_wr_n != rx_rd_n);
      tx_space_o <= ~((tx_wr_n[TAW] != tx_rd_n[TAW]) && (tx_wr_n[TAW-1:0] == tx_rd_n[TAW-1:0]));
      irq_o      <= (rx_wr_n != rx_rd_n) | ovr_n | fe_n | txovf_n | pe_n;
    end
  end

`ifdef ACIA_PARITY_EN
  // Parity error flag
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) pe <= 1'b0;
    else         pe <= pe_n;
  end
`endif

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr[TAW-1:0]] <= din_i[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wr[RAW-1:0]] <= rx_shift;
  end

  // TX bit engine: each bit held for exactly DIV clocks
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_st    <= T_IDLE;
      tx_o     <= 1'b1;
      tx_tmr   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
`ifdef ACIA_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_st    <= T_START;
      tx_o     <= 1'b0;
      tx_tmr   <= '0;
      tx_shift <= tx_head;
`ifdef ACIA_PARITY_EN
      tx_par   <= ^tx_head ^ 1'(PARITY_ODD);
`endif
    end else if (tx_st != T_IDLE) begin
      if (!tx_bit_end) begin
        tx_tmr <= tx_tmr + 1'b1;
      end else begin
        tx_tmr <= '0;
        case (tx_st)
          T_START: begin
            tx_st    <= T_DATA;
            tx_idx   <= '0;
            tx_o     <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end
          T_DATA: begin
            if (tx_idx == 3'(DATA_BITS - 1)) begin
              tx_idx <= '0;
`ifdef ACIA_PARITY_EN
              tx_st  <= T_PAR;
              tx_o   <= tx_par;
`else
              tx_st  <= T_STOP;
              tx_o   <= 1'b1;
`endif
            end else begin
              tx_idx   <= tx_idx + 1'b1;
              tx_o     <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
            end
          end
          T_PAR: begin
            tx_st  <= T_STOP;
            tx_idx <= '0;
            tx_o   <= 1'b1;
          end
          T_STOP: begin
            if (tx_idx == 3'(STOP_BITS - 1)) tx_st  <= T_IDLE;
            else                             tx_idx <= tx_idx + 1'b1;
          end
          default: tx_st <= T_IDLE;
        endcase
      end
    end
  end

  // rx_i synchroniser plus one extra stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // RX bit engine: start bit checked at half a bit, later bits sampled mid-bit
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_st    <= R_IDLE;
      rx_tmr   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef ACIA_PARITY_EN
      rx_pbad  <= 1'b0;
`endif
    end else begin
      case (rx_st)
        R_IDLE: begin
          if (rx_prev & ~rx_sync) begin
            rx_st  <= R_START;
            rx_tmr <= '0;
          end
        end
        R_START: begin
          if (rx_tmr == TW'(DIV / 2 - 1)) begin
            rx_tmr <= '0;
            rx_idx <= '0;
            rx_st  <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        R_DATA: begin
          if (rx_bit_end) begin
            rx_tmr   <= '0;
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_idx == 3'(DATA_BITS - 1)) begin
`ifdef ACIA_PARITY_EN
              rx_st <= R_PAR;
`else
              rx_st <= R_STOP;
`endif
            end else begin
              rx_idx <= rx_idx + 1'b1;
            end
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
`ifdef ACIA_PARITY_EN
        R_PAR: begin
          if (rx_bit_end) begin
            rx_tmr  <= '0;
            rx_pbad <= ^rx_shift ^ rx_sync ^ 1'(PARITY_ODD);
            rx_st   <= R_STOP;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
`endif
        R_STOP: begin
          if (rx_bit_end) begin
            rx_tmr <= '0;
            rx_st  <= rx_sync ? R_IDLE : R_BREAK;
          end else begin
            rx_tmr <= rx_tmr + 1'b1;
          end
        end
        R_BREAK: begin
          if (rx_sync) rx_st <= R_IDLE;
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acia_fifo.sv
// Testbench for acia_fifo at DIV=10 (1 MHz clock, 100 kbit/s), 8N1 by default,
// 7 data bits with even parity when ACIA_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_acia_fifo;
`ifdef ACIA_PARITY_EN
  localparam int DB = 7;
`else
  localparam int DB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic       rd_i = 1'b0, wr_i = 1'b0, rs_i = 1'b0;
  logic [7:0] din_i = 8'h00;
  logic [7:0] dout_o;
  logic       rx_i, tx_o, rx_avail_o, tx_space_o, irq_o;
  logic       rx_drv = 1'b1;
  logic       loopback = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         cyc_cnt = 0;

  logic [7:0] mon_bytes[$];
  longint     mon_times[$];
  logic       mon_par[$];
  logic [7:0] mon_b;
  longint     mon_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  assign rx_i = loopback ? tx_o : rx_drv;

  acia_fifo #(
    .CLK_HZ(1_000_000), .BPS_RATE(100_000), .DATA_BITS(DB), .STOP_BITS(1),
    .TX_DEPTH(4), .RX_DEPTH(4), .PARITY_ODD(0)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .rd_i(rd_i), .wr_i(wr_i), .rs_i(rs_i),
    .din_i(din_i), .dout_o(dout_o), .rx_i(rx_i), .tx_o(tx_o),
    .rx_avail_o(rx_avail_o), .tx_space_o(tx_space_o), .irq_o(irq_o)
  );

  // Serial decoder on tx_o, sampling mid-bit on the falling clock edge
  always begin
    @(negedge tx_o);
    if (rst_ni) begin
      mon_t = $time;
      mon_b = 8'h00;
      repeat (5) @(negedge clk);
      for (int i = 0; i < DB; i++) begin
        repeat (10) @(negedge clk);
        mon_b[i] = tx_o;
      end
`ifdef ACIA_PARITY_EN
      repeat (10) @(negedge clk);
      mon_par.push_back(tx_o);
`endif
      repeat (10) @(negedge clk);
      mon_bytes.push_back(mon_b);
      mon_times.push_back(mon_t);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_data(input logic [7:0] d);
    rs_i = 1'b1; wr_i = 1'b1; din_i = d;
    cyc(1);
    wr_i = 1'b0;
  endtask

  task automatic wr_ctl(input logic [7:0] d);
    rs_i = 1'b0; wr_i = 1'b1; din_i = d;
    cyc(1);
    wr_i = 1'b0;
  endtask

  task automatic rd_status(output logic [7:0] v);
    rs_i = 1'b0; rd_i = 1'b1;
    cyc(1);
    rd_i = 1'b0;
    v = dout_o;
  endtask

  task automatic rd_data(output logic [7:0] v);
    rs_i = 1'b1; rd_i = 1'b1;
    cyc(1);
    rd_i = 1'b0;
    v = dout_o;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
    rx_drv = 1'b0;
    cyc(10);
    for (int i = 0; i < DB; i++) begin
      rx_drv = b[i];
      cyc(10);
    end
`ifdef ACIA_PARITY_EN
    rx_drv = par;
    cyc(10);
`else
    if (par) rx_drv = 1'b1;
`endif
    rx_drv = stop;
    cyc(10);
    rx_drv = 1'b1;
  endtask

  typedef struct {
    logic       wr, rd, rs;
    logic [7:0] din;
    logic       chk_d;
    logic [7:0] dout;
    logic       txs, irq;
  } vec_t;
  vec_t vt[9];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int t0, t1, n;
    logic [7:0] exp_tx[5];
    logic [7:0] exp_rx[4];
    exp_tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_rx = '{8'h01, 8'h02, 8'h03, 8'h04};

    // TX overflow sequence, one bus cycle per record
    vt[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};

    #2;
    rst_ni = 1'b0;
    cyc(3);
    check("reset tx_o", tx_o, 1);
    check("reset dout_o", dout_o, 8'h00);
    check("reset rx_avail_o", rx_avail_o, 0);
    check("reset tx_space_o", tx_space_o, 1);
    check("reset irq_o", irq_o, 0);
    rst_ni = 1'b1;
    cyc(2);

`ifndef ACIA_PARITY_EN
    for (int i = 0; i < 9; i++) begin
      wr_i = vt[i].wr; rd_i = vt[i].rd; rs_i = vt[i].rs; din_i = vt[i].din;
      cyc(1);
      wr_i = 1'b0; rd_i = 1'b0;
      if (vt[i].chk_d) check($sformatf("vec%0d dout", i), dout_o, vt[i].dout);
      check($sformatf("vec%0d tx_space", i), tx_space_o, vt[i].txs);
      check($sformatf("vec%0d irq", i), irq_o, vt[i].irq);
    end
    cyc(560);
    check("txovf frames sent", mon_bytes.size(), 5);
    for (int i = 0; i < mon_bytes.size() && i < 5; i++)
      check($sformatf("txovf byte%0d", i), mon_bytes[i], exp_tx[i]);
    rd_status(v);
    check("txovf idle status", v, 8'h0A);

    // Loopback, three back-to-back frames
    mon_bytes.delete(); mon_times.delete();
    loopback = 1'b1;
    wr_data(8'hA5);
    t0 = cyc_cnt;
    wr_data(8'h3C);
    wr_data(8'hFF);
    rs_i = 1'b0;
    n = 0;
    while (n < 400) begin
      cyc(1);
      n++;
      if (dout_o[3]) break;
    end
    t1 = cyc_cnt;
    check("loop txi latency 300..304", (t1 - t0 >= 300) && (t1 - t0 <= 304), 1);
    check("loop frames seen", mon_times.size(), 3);
    if (mon_times.size() >= 3) begin
      check("loop gap 1", 32'(mon_times[1] - mon_times[0]), 1000);
      check("loop gap 2", 32'(mon_times[2] - mon_times[1]), 1000);
    end
    cyc(10);
    check("loop rx_avail", rx_avail_o, 1);
    rd_data(v); check("loop rx byte0", v, 8'hA5);
    rd_data(v); check("loop rx byte1", v, 8'h3C);
    rd_data(v); check("loop rx byte2", v, 8'hFF);
    check("loop rx drained", rx_avail_o, 0);
    loopback = 1'b0;
    cyc(5);

    // RX overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    cyc(20);
    check("ovr rx_avail", rx_avail_o, 1);
    rd_status(v);
    check("ovr status", v, 8'h0F);
    check("ovr irq held by data", irq_o, 1);
    for (int i = 0; i < 4; i++) begin
      rd_data(v);
      check($sformatf("ovr byte%0d", i), v, exp_rx[i]);
    end
    check("ovr rx_avail after drain", rx_avail_o, 0);
    check("ovr irq after drain", irq_o, 0);
    rd_status(v);
    check("ovr status cleared", v, 8'h0A);

    // Framing error followed by a long break, then a good frame
    send_frame(8'h55, 1'b0, 1'b0);
    rx_drv = 1'b0;
    cyc(300);
    rx_drv = 1'b1;
    cyc(20);
    send_frame(8'h12, 1'b1, 1'b0);
    cyc(20);
    rd_status(v);
    check("fe status", v, 8'h1B);
    rd_data(v);
    check("fe good byte", v, 8'h12);
    check("fe only one byte", rx_avail_o, 0);

    // RX flush through the control register
    send_frame(8'h77, 1'b1, 1'b0);
    cyc(20);
    check("flush rx_avail before", rx_avail_o, 1);
    wr_ctl(8'h01);
    check("flush rx_avail after", rx_avail_o, 0);

    // Short low glitch is rejected
    rx_drv = 1'b0;
    cyc(3);
    rx_drv = 1'b1;
    cyc(30);
    check("glitch rx_avail", rx_avail_o, 0);
    rd_status(v);
    check("glitch status", v, 8'h0A);

    // Reset in the middle of a TX frame
    wr_data(8'h81);
    cyc(30);
    check("midframe tx_o low", tx_o, 0);
    rst_ni = 1'b0;
    #1;
    check("midframe reset tx_o", tx_o, 1);
    check("midframe reset tx_space", tx_space_o, 1);
    check("midframe reset dout", dout_o, 8'h00);
    cyc(2);
    rst_ni = 1'b1;
    cyc(2);
    rd_status(v);
    check("midframe post-reset status", v, 8'h0A);
`else
    // Parity: 7 data bits, even parity
    wr_data(8'h07);
    cyc(120);
    check("par tx frames", mon_bytes.size(), 1);
    if (mon_bytes.size() >= 1) begin
      check("par tx byte", mon_bytes[0], 8'h07);
      check("par tx parity bit", mon_par[0], 1);
    end
    send_frame(8'h07, 1'b1, 1'b0);
    cyc(20);
    rd_status(v);
    check("par rx status", v, 8'h2B);
    rd_data(v);
    check("par rx byte", v, 8'h07);
    rd_status(v);
    check("par status cleared", v, 8'h0A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
